// File: rtl/aes_arkey_iter_pkg.sv
// Shared AES constants and types for the iterative AddRoundKey unit and the round stages.
// The state is byte-packed so that element 4*j+i is row i of column j.
package aes_arkey_iter_pkg;
   localparam int Nb     = 4;
   localparam int Nr     = 10;
   localparam int COL_W  = $clog2(Nb) + 1;
   localparam int CIDX_W = $clog2(Nb);
   localparam int KIDX_W = $clog2(Nb * (Nr + 1));

   typedef enum logic [1:0] {IDLE, BUSY, DONE} arkey_fsm_t;

   typedef logic [4*Nb-1:0][7:0]       aes_state_t;
   typedef logic [3:0][7:0]            aes_col_t;
   typedef logic [Nb*(Nr+1)-1:0][31:0] aes_kexp_t;
endpackage

// File: rtl/aes_arkey_col.sv
// One state column XORed with one key word; key byte 0 sits in the word's MSB.
module aes_arkey_col
   import aes_arkey_iter_pkg::*;
(
   input  aes_col_t    col_i,
   input  logic [31:0] key_i,
   output aes_col_t    col_o
);
   always_comb begin
      for (int i = 0; i < 4; i++) begin
         col_o[i] = col_i[i] ^ key_i[31-8*i -: 8];
      end
   end
endmodule

// File: rtl/aes_arkey_iter.sv
// Iterative AddRoundKey: LANES columns per cycle, runtime round select, valid/ready on both sides.
// Optional out-of-range round detection is built when AES_ARKEY_RCHK_EN is defined.
module aes_arkey_iter
   import aes_arkey_iter_pkg::*;
#(
   parameter int LANES = 1
) (
   input  logic       clock_i,
   input  logic       reset_i,
   input  logic       in_valid_i,
   output logic       in_ready_o,
   input  logic [3:0] in_round_i,
   input  aes_state_t in_state_i,
   input  aes_kexp_t  kexp_i,
   output logic       out_valid_o,
   input  logic       out_ready_i,
   output aes_state_t out_state_o,
   output logic [3:0] out_round_o,
   output logic       out_err_o
);
   arkey_fsm_t       state_q, state_d;
   aes_state_t       st_q, st_d, st_xor;
   aes_state_t       ost_q, ost_d;
   logic [3:0]       rnd_q, rnd_d;
   logic [3:0]       ornd_q, ornd_d;
   logic [COL_W-1:0] col_q, col_d;
   logic             last_col;
   logic             accept;

   aes_col_t [LANES-1:0]            lane_res;
   logic [LANES-1:0][CIDX_W+1:0]    lane_bidx;

`ifdef AES_ARKEY_RCHK_EN
   logic err_q, err_d;
   logic oerr_q, oerr_d;
`endif

   for (genvar l = 0; l < LANES; l++) begin : g_lane
      logic [CIDX_W-1:0] j;
      logic [KIDX_W-1:0] kidx;

      assign j            = col_q[CIDX_W-1:0] + CIDX_W'(l);
      assign kidx         = KIDX_W'(rnd_q) * KIDX_W'(Nb) + KIDX_W'(j);
      assign lane_bidx[l] = {j, 2'b00};

      aes_arkey_col u_col (
         .col_i (st_q[lane_bidx[l] +: 4]),
         .key_i (kexp_i[kidx]),
         .col_o (lane_res[l])
      );
   end

   always_comb begin
      st_xor = st_q;
      for (int l = 0; l < LANES; l++) begin
         st_xor[lane_bidx[l] +: 4] = lane_res[l];
      end
`ifdef AES_ARKEY_RCHK_EN
      // Out-of-range blocks still burn the BUSY cycles but pass through untouched.
      if (err_q) st_xor = st_q;
`endif
   end

   assign last_col = (col_q + COL_W'(LANES)) == COL_W'(Nb);

   always_comb begin
      state_d    = state_q;
      st_d       = st_q;
      rnd_d      = rnd_q;
      col_d      = col_q;
      ost_d      = ost_q;
      ornd_d     = ornd_q;
      in_ready_o = 1'b0;
      accept     = 1'b0;
`ifdef AES_ARKEY_RCHK_EN
      err_d      = err_q;
      oerr_d     = oerr_q;
`endif
      case (state_q)
         IDLE: begin
            in_ready_o = 1'b1;
            accept     = in_valid_i;
         end
         BUSY: begin
            st_d  = st_xor;
            col_d = col_q + COL_W'(LANES);
            if (last_col) begin
               state_d = DONE;
               ost_d   = st_xor;
               ornd_d  = rnd_q;
`ifdef AES_ARKEY_RCHK_EN
               oerr_d  = err_q;
`endif
            end
         end
         DONE: begin
            in_ready_o = out_ready_i;
            if (out_ready_i) begin
               state_d = IDLE;
               accept  = in_valid_i;
            end
         end
         default: state_d = IDLE;
      endcase

      if (accept) begin
         state_d = BUSY;
         st_d    = in_state_i;
         rnd_d   = in_round_i;
         col_d   = '0;
`ifdef AES_ARKEY_RCHK_EN
         err_d   = in_round_i > 4'(Nr);
`endif
      end
   end

   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         state_q <= IDLE;
         st_q    <= '0;
         rnd_q   <= '0;
         col_q   <= '0;
         ost_q   <= '0;
         ornd_q  <= '0;
`ifdef AES_ARKEY_RCHK_EN
         err_q   <= 1'b0;
         oerr_q  <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         st_q    <= st_d;
         rnd_q   <= rnd_d;
         col_q   <= col_d;
         ost_q   <= ost_d;
         ornd_q  <= ornd_d;
`ifdef AES_ARKEY_RCHK_EN
         err_q   <= err_d;
         oerr_q  <= oerr_d;
`endif
      end
   end

   assign out_valid_o = (state_q == DONE);
   assign out_state_o = ost_q;
   assign out_round_o = ornd_q;
`ifdef AES_ARKEY_RCHK_EN
   assign out_err_o   = oerr_q;
`else
   assign out_err_o   = 1'b0;
`endif
endmodule

// File: tb/tb_aes_arkey_iter.sv
// Bench for aes_arkey_iter: LANES=1,2,4 side by side, queued expectations checked by a per-DUT monitor.
module tb_aes_arkey_iter;
   import aes_arkey_iter_pkg::*;

   typedef struct {
      aes_state_t st;
      logic [3:0] rnd;
      logic       err;
      int         acc;
   } exp_t;

   logic clk = 1'b0;
   int   cyc = 0;
   int   n_pass = 0;
   int   n_total = 0;
   bit   done [3];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
      n_total++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got %0h, required %0h", nm, act, req);
   endtask

   function automatic aes_state_t from_hex(input logic [127:0] v);
      aes_state_t s;
      for (int b = 0; b < 4*Nb; b++) s[b] = v[127-8*b -: 8];
      return s;
   endfunction

   // Reference: byte b belongs to column b/4, row b%4; XOR with that row's byte of word r*Nb+column.
   function automatic aes_state_t ref_ark(input aes_state_t s, input int r, input aes_kexp_t k);
      aes_state_t  o;
      logic [31:0] w;
      for (int b = 0; b < 4*Nb; b++) begin
         w    = k[r*Nb + b/4];
         o[b] = s[b] ^ w[31-8*(b%4) -: 8];
      end
      return o;
   endfunction

   function automatic aes_state_t rand_state();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   for (genvar g = 0; g < 3; g++) begin : g_dut
      localparam int L     = 1 << g;
      localparam int LAT   = Nb / L;
      localparam int RST_K = (L == 4) ? 0 : 2 / L;

      logic       reset, in_valid, in_ready, out_valid, out_ready, out_err;
      logic [3:0] in_round, out_round;
      aes_state_t in_state, out_state;
      aes_kexp_t  kexp;
      exp_t       exp_q[$];
      bit         lat_done = 1'b0;
      bit         bp_en = 1'b0;

      aes_arkey_iter #(.LANES(L)) u_dut (
         .clock_i     (clk),
         .reset_i     (reset),
         .in_valid_i  (in_valid),
         .in_ready_o  (in_ready),
         .in_round_i  (in_round),
         .in_state_i  (in_state),
         .kexp_i      (kexp),
         .out_valid_o (out_valid),
         .out_ready_i (out_ready),
         .out_state_o (out_state),
         .out_round_o (out_round),
         .out_err_o   (out_err)
      );

      task automatic tick();
         @(posedge clk);
         #1;
         if (bp_en) out_ready = ($urandom_range(0, 3) != 0);
      endtask

      task automatic send(input aes_state_t s, input logic [3:0] r, input aes_state_t e,
                          input logic er, output logic ov);
         bit   got = 1'b0;
         int   n = 0;
         exp_t x;
         ov       = 1'b0;
         in_state = s;
         in_round = r;
         in_valid = 1'b1;
         while (!got && n < 200) begin
            @(negedge clk);
            if (in_ready) begin
               got   = 1'b1;
               ov    = out_valid;
               x.st  = e;
               x.rnd = r;
               x.err = er;
               x.acc = cyc + 1;
               exp_q.push_back(x);
            end
            n++;
            tick();
         end
         in_valid = 1'b0;
         chk($sformatf("L%0d_accept", L), got, 1);
      endtask

      task automatic drain();
         int n = 0;
         while (exp_q.size() != 0 && n < 500) begin
            tick();
            n++;
         end
         chk($sformatf("L%0d_drain", L), exp_q.size(), 0);
      endtask

      always @(negedge clk) begin : mon
         exp_t e;
         if (!reset && out_valid) begin
            if (exp_q.size() == 0) begin
               chk($sformatf("L%0d_unexpected_out", L), out_valid, 0);
            end else begin
               if (!lat_done) begin
                  chk($sformatf("L%0d_latency", L), cyc - exp_q[0].acc, LAT);
                  lat_done = 1'b1;
               end
               if (out_ready) begin
                  e = exp_q.pop_front();
                  chk($sformatf("L%0d_out_state", L), out_state, e.st);
                  chk($sformatf("L%0d_out_round", L), out_round, e.rnd);
                  chk($sformatf("L%0d_out_err", L), out_err, e.err);
                  lat_done = 1'b0;
               end
            end
         end
      end

      initial begin : stim
         aes_state_t  s, s2, e;
         logic        ov;
         int          r;
         logic [127:0] fips_in, fips_out;
         fips_in  = 128'h3243f6a8885a308d313198a2e0370734;
         fips_out = 128'h193de3bea0f4e22b9ac68d2ae9f84808;

         reset     = 1'b1;
         in_valid  = 1'b0;
         in_round  = '0;
         in_state  = '0;
         out_ready = 1'b1;
         for (int w = 0; w < Nb*(Nr+1); w++) kexp[w] = $urandom();
         repeat (3) @(posedge clk);
         #1 reset = 1'b0;

         @(negedge clk);
         chk($sformatf("L%0d_rst_in_ready", L), in_ready, 1);
         chk($sformatf("L%0d_rst_out_valid", L), out_valid, 0);
         chk($sformatf("L%0d_rst_out_state", L), out_state, 0);
         chk($sformatf("L%0d_rst_out_round", L), out_round, 0);
         chk($sformatf("L%0d_rst_out_err", L), out_err, 0);
         tick();

         kexp[0] = 32'h2b7e1516;
         kexp[1] = 32'h28aed2a6;
         kexp[2] = 32'habf71588;
         kexp[3] = 32'h09cf4f3c;
         send(from_hex(fips_in), 4'd0, from_hex(fips_out), 1'b0, ov);
         drain();

         s  = rand_state();
         s2 = rand_state();
         send(s, 4'd0, ref_ark(s, 0, kexp), 1'b0, ov);
         send(s2, 4'(Nr), ref_ark(s2, Nr, kexp), 1'b0, ov);
         chk($sformatf("L%0d_b2b_accept_in_done", L), ov, 1);
         drain();

         out_ready = 1'b0;
         r = $urandom_range(0, Nr);
         s = rand_state();
         e = ref_ark(s, r, kexp);
         send(s, 4'(r), e, 1'b0, ov);
         begin
            int n = 0;
            @(negedge clk);
            while (!out_valid && n < 50) begin
               tick();
               @(negedge clk);
               n++;
            end
         end
         for (int i = 0; i < 10; i++) begin
            chk($sformatf("L%0d_bp_valid", L), out_valid, 1);
            chk($sformatf("L%0d_bp_state", L), out_state, e);
            chk($sformatf("L%0d_bp_round", L), out_round, r);
            chk($sformatf("L%0d_bp_in_ready", L), in_ready, 0);
            tick();
            @(negedge clk);
         end
         @(posedge clk);
         #1 out_ready = 1'b1;
         @(negedge clk);
         @(negedge clk);
         chk($sformatf("L%0d_bp_consumed", L), out_valid, 0);
         tick();

         s = rand_state();
         send(s, 4'd0, ref_ark(s, 0, kexp), 1'b0, ov);
         for (int i = 0; i < RST_K; i++) begin
            @(posedge clk);
            #1;
         end
         reset = 1'b1;
         exp_q.delete();
         lat_done = 1'b0;
         @(posedge clk);
         #1 reset = 1'b0;
         @(negedge clk);
         chk($sformatf("L%0d_midrst_fsm", L), u_dut.state_q, IDLE);
         chk($sformatf("L%0d_midrst_out_valid", L), out_valid, 0);
         chk($sformatf("L%0d_midrst_out_state", L), out_state, 0);
         chk($sformatf("L%0d_midrst_in_ready", L), in_ready, 1);
         tick();

`ifdef AES_ARKEY_RCHK_EN
         s = rand_state();
         send(s, 4'(Nr + 1), s, 1'b1, ov);
         s2 = rand_state();
         send(s2, 4'd0, ref_ark(s2, 0, kexp), 1'b0, ov);
         drain();
`endif

         for (int w = 0; w < Nb*(Nr+1); w++) kexp[w] = $urandom();
         bp_en = 1'b1;
         for (int i = 0; i < 30; i++) begin
            s = rand_state();
            r = $urandom_range(0, Nr);
            send(s, 4'(r), ref_ark(s, r, kexp), 1'b0, ov);
            if ($urandom_range(0, 2) == 0) tick();
         end
         drain();
         bp_en     = 1'b0;
         out_ready = 1'b1;
         done[g]   = 1'b1;
      end
   end

   initial begin : main
      int n = 0;
      while (!(done[0] && done[1] && done[2]) && n < 20000) begin
         @(posedge clk);
         n++;
      end
      chk("all_done", {done[0], done[1], done[2]}, 3'b111);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
